// File: rtl/ahb_sram_bridge.sv
// AHB-Lite zero-wait-state slave in front of a single-port word-wide SRAM.
// A one-entry write buffer parks a write data phase that collides with a read address phase.
module ahb_sram_bridge #(
  parameter int AW = 16
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL,
  input  logic          HREADY,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [AW+1:0] HADDR,
  input  logic [31:0]   HWDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  input  logic [31:0]   SRAMRDATA,
  output logic [AW-1:0] SRAMADDR,
  output logic [31:0]   SRAMWDATA,
  output logic [3:0]    SRAMWEN,
  output logic          SRAMCS
);

  function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] lane);
    if (size == 3'd0)      return 4'b0001 << lane;
    else if (size == 3'd1) return lane[1] ? 4'b1100 : 4'b0011;
    else                   return 4'b1111;
  endfunction

  logic          accept, rd_accept, wr_accept;
  logic          wr_dp, rd_dp;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [3:0]    wr_mask;
  logic          buf_valid;
  logic [AW-1:0] buf_addr;
  logic [3:0]    buf_mask;
  logic [31:0]   buf_data;
  logic          drain;

  assign accept    = HSEL & HREADY & HTRANS[1];
  assign rd_accept = accept & ~HWRITE;
  assign wr_accept = accept & HWRITE;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  // Port arbitration: read address phase, then direct write data, then buffer drain.
  // Everything is suppressed while in reset so an in-flight write never lands.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    SRAMCS    = 1'b0;
    SRAMWEN   = 4'b0000;
    SRAMADDR  = '0;
    SRAMWDATA = '0;
    drain     = 1'b0;
    if (!HRESET) begin
      if (rd_accept) begin
        SRAMCS   = 1'b1;
        SRAMADDR = HADDR[AW+1:2];
      end else if (wr_dp) begin
        SRAMCS    = 1'b1;
        SRAMWEN   = wr_mask;
        SRAMADDR  = wr_addr;
        SRAMWDATA = HWDATA;
      end else if (buf_valid) begin
        SRAMCS    = 1'b1;
        SRAMWEN   = buf_mask;
        SRAMADDR  = buf_addr;
        SRAMWDATA = buf_data;
        drain     = 1'b1;
      end
    end
  end

  // Merge uses buffer state from the start of the cycle, so a concurrent drain is harmless.
  always_comb begin
    HRDATA = '0;
    if (rd_dp) begin
      HRDATA = SRAMRDATA;
      if (buf_valid && (buf_addr == rd_addr)) begin
        for (int b = 0; b < 4; b++) begin
          if (buf_mask[b]) HRDATA[b*8 +: 8] = buf_data[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    if (HRESET) begin
      wr_dp     <= 1'b0;
      rd_dp     <= 1'b0;
      wr_addr   <= '0;
      wr_mask   <= '0;
      rd_addr   <= '0;
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_mask  <= '0;
      buf_data  <= '0;
    end else begin
      wr_dp <= wr_accept;
      rd_dp <= rd_accept;
      if (wr_accept) begin
        wr_addr <= HADDR[AW+1:2];
        wr_mask <= byte_mask(HSIZE, HADDR[1:0]);
      end
      if (rd_accept) rd_addr <= HADDR[AW+1:2];
      if (wr_dp && rd_accept) begin
        buf_valid <= 1'b1;
        buf_addr  <= wr_addr;
        buf_mask  <= wr_mask;
        buf_data  <= HWDATA;
      end else if (drain) begin
        buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// Directed and random self-checking bench for ahb_sram_bridge with a behavioural SRAM
// and an AHB-level reference memory model.
module tb_ahb_sram_bridge;
  localparam int AW = 16;

  logic          HCLK = 1'b0;
  logic          HRESET, HSEL, HREADY, HWRITE;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic [AW+1:0] HADDR;
  logic [31:0]   HWDATA;
  logic          HREADYOUT, HRESP;
  logic [31:0]   HRDATA, SRAMRDATA;
  logic [AW-1:0] SRAMADDR;
  logic [31:0]   SRAMWDATA;
  logic [3:0]    SRAMWEN;
  logic          SRAMCS;

  bit [31:0] mem [0:(1<<AW)-1];
  bit [31:0] model [0:15];
  int passed = 0, fails = 0, total = 0;

  logic        w, hr, tr, acc, p_wr, p_rd;
  int          word, off, p_word;
  logic [2:0]  sz;
  logic [3:0]  msk, p_mask;
  logic [31:0] d;

  ahb_sram_bridge #(.AW(AW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .SRAMRDATA(SRAMRDATA),
    .SRAMADDR(SRAMADDR), .SRAMWDATA(SRAMWDATA), .SRAMWEN(SRAMWEN), .SRAMCS(SRAMCS)
  );

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) begin
    if (SRAMCS) begin
      if (SRAMWEN == 4'b0000) SRAMRDATA <= mem[SRAMADDR];
      else
        for (int b = 0; b < 4; b++)
          if (SRAMWEN[b]) mem[SRAMADDR][b*8 +: 8] <= SRAMWDATA[b*8 +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic bus(input logic wr, input logic [AW+1:0] a, input logic [2:0] size);
    HSEL = 1'b1; HREADY = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = a; HSIZE = size;
  endtask

  task automatic idle();
    HSEL = 1'b0; HREADY = 1'b1; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  initial begin
    // Reset with random idle bus inputs
    HRESET = 1'b1; idle();
    HSEL = 1'($urandom); HWRITE = 1'($urandom); HADDR = (AW+2)'($urandom);
    HSIZE = 3'($urandom); HWDATA = $urandom;
    step(); step();
    HRESET = 1'b0; idle(); settle();
    check("rst_cs", 32'(SRAMCS), 32'd0);
    check("rst_wen", 32'(SRAMWEN), 32'd0);
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst_hresp", 32'(HRESP), 32'd0);
    check("rst_addr", 32'(SRAMADDR), 32'd0);
    check("rst_wdata", SRAMWDATA, 32'd0);
    step();

    // Word write then read back
    bus(1'b1, 'h10, 3'd2); step();
    idle(); HWDATA = 32'hDEADBEEF; settle();
    check("wr_cs", 32'(SRAMCS), 32'd1);
    check("wr_wen", 32'(SRAMWEN), 32'hF);
    check("wr_addr", 32'(SRAMADDR), 32'd4);
    check("wr_wdata", SRAMWDATA, 32'hDEADBEEF);
    step();
    bus(1'b0, 'h10, 3'd2); settle();
    check("rd_cs", 32'(SRAMCS), 32'd1);
    check("rd_wen", 32'(SRAMWEN), 32'd0);
    check("rd_addr", 32'(SRAMADDR), 32'd4);
    step();
    idle(); settle();
    check("rd_data", HRDATA, 32'hDEADBEEF);
    step();

    // Byte write colliding with a read: buffered, merged, then drained
    bus(1'b1, 'h10, 3'd2); step();
    idle(); HWDATA = 32'h11223344; step();
    bus(1'b1, 'h13, 3'd0); step();
    bus(1'b0, 'h10, 3'd2); HWDATA = 32'hAB000000; settle();
    check("coll_wen", 32'(SRAMWEN), 32'd0);
    check("coll_addr", 32'(SRAMADDR), 32'd4);
    step();
    idle(); settle();
    check("merge_data", HRDATA, 32'hAB223344);
    check("drain_wen", 32'(SRAMWEN), 32'h8);
    check("drain_addr", 32'(SRAMADDR), 32'd4);
    check("drain_wdata", SRAMWDATA, 32'hAB000000);
    step();
    check("drain_mem", mem[4], 32'hAB223344);

    // Back-to-back halfword writes
    bus(1'b1, 'h22, 3'd1); step();
    bus(1'b1, 'h20, 3'd1); HWDATA = 32'hCAFE0000; settle();
    check("hw_hi_wen", 32'(SRAMWEN), 32'hC);
    check("hw_hi_addr", 32'(SRAMADDR), 32'd8);
    step();
    idle(); HWDATA = 32'h0000BEEF; settle();
    check("hw_lo_wen", 32'(SRAMWEN), 32'h3);
    check("hw_lo_addr", 32'(SRAMADDR), 32'd8);
    step();
    bus(1'b0, 'h20, 3'd2); step();
    idle(); settle();
    check("hw_rd", HRDATA, 32'hCAFEBEEF);
    step();

    // Reset while a write sits in the buffer discards it
    bus(1'b1, 'h40, 3'd2); step();
    idle(); HWDATA = 32'h12345678; step();
    bus(1'b1, 'h40, 3'd2); step();
    bus(1'b0, 'h44, 3'd2); HWDATA = 32'h99999999; step();
    idle(); HRESET = 1'b1; settle();
    check("rstmid_wen", 32'(SRAMWEN), 32'd0);
    step();
    HRESET = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("post_rst_wen", 32'(SRAMWEN), 32'd0);
      step();
    end
    check("rstmid_mem", mem[16], 32'h12345678);
    bus(1'b0, 'h40, 3'd2); step();
    idle(); settle();
    check("rstmid_rd", HRDATA, 32'h12345678);
    step();

    // Random mixed traffic on words 32..47 against the reference model
    p_wr = 1'b0; p_rd = 1'b0; p_word = 0; p_mask = 4'b0;
    for (int i = 0; i < 200; i++) begin
      d = $urandom;
      HWDATA = d;
      if (p_wr)
        for (int b = 0; b < 4; b++)
          if (p_mask[b]) model[p_word][b*8 +: 8] = d[b*8 +: 8];
      w    = (i < 40) ? (i % 2 == 0) : 1'($urandom_range(0, 1));
      hr   = ($urandom_range(0, 7) != 0);
      tr   = (i < 40) ? 1'b1 : ($urandom_range(0, 5) != 0);
      sz   = 3'($urandom_range(0, 2));
      word = $urandom_range(0, 15);
      off  = (sz == 3'd0) ? $urandom_range(0, 3) : (sz == 3'd1) ? 2 * $urandom_range(0, 1) : 0;
      msk  = (sz == 3'd0) ? 4'(1 << off) : (sz == 3'd1) ? ((off == 2) ? 4'hC : 4'h3) : 4'hF;
      HSEL = 1'b1; HREADY = hr; HTRANS = tr ? 2'b10 : 2'b00; HWRITE = w;
      HSIZE = sz; HADDR = (AW+2)'((32 + word) * 4 + off);
      acc = tr & hr;
      settle();
      if (p_rd) check("rand_rd", HRDATA, model[p_word]);
      check("no_overflow", 32'(dut.buf_valid & dut.wr_dp & acc & ~w), 32'd0);
      p_wr = acc & w; p_rd = acc & ~w; p_word = word; p_mask = msk;
      step();
    end
    idle();
    d = $urandom;
    HWDATA = d;
    if (p_wr)
      for (int b = 0; b < 4; b++)
        if (p_mask[b]) model[p_word][b*8 +: 8] = d[b*8 +: 8];
    settle();
    if (p_rd) check("rand_rd_last", HRDATA, model[p_word]);
    step(); step(); step();
    for (int k = 0; k < 16; k++) check("final_image", mem[32 + k], model[k]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
